// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - two-byte instruction fetch unit with decoder handshake and PC control
//
// Purpose: reads a 16-bit instruction as two byte reads (high byte at pc_count,
// low byte at pc_count+1), presents it to the decoder with instr_valid/instr_ready,
// then pulses IncPC or LoadPC and waits SETTLE_CYC cycles for the counter to settle.
//
// Ports:
//   clk, reset (async, active-low)    clock and reset
//   run                               level enable for fetching
//   pc_count                          current program address
//   mem_rd/mem_addr/mem_data/mem_valid byte-wide memory read interface
//   instr/instr_valid/instr_ready     decoder handshake
//   br_take/br_target                 branch request, sampled on accept
//   IncPC/LoadPC/new_count            program counter control pulses
//   halted                            sticky, HALT_OP consumed
//   fetch_err                         sticky, memory timeout
//
// Optional feature: define FETCH_TIMEOUT_EN to enable the memory response timeout.

module instruction_fetch #(
  parameter int         ADDR_W      = 8,
  parameter logic [3:0] HALT_OP     = 4'b1111,
  parameter int         SETTLE_CYC  = 2,
  parameter int         TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              br_take,
  input  logic [ADDR_W-1:0] br_target,
  output logic              IncPC,
  output logic              LoadPC,
  output logic [ADDR_W-1:0] new_count,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI, S_GAP, S_RD_LO, S_PRESENT, S_SETTLE, S_HALT, S_ERR
  } state_t;

  state_t            r_state;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_instr;
  logic              r_instr_valid;
  logic              r_inc_pc;
  logic              r_load_pc;
  logic [ADDR_W-1:0] r_new_count;
  logic              r_halted;
  logic [2:0]        r_settle_cnt;

  logic [ADDR_W-1:0] w_addr_lo;
  logic              w_timeout;

  // Low byte address wraps naturally modulo 2^ADDR_W.
  assign w_addr_lo = pc_count + ADDR_W'(1);

`ifdef FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_fetch_err;

  // Fires on the last of TIMEOUT_CYC request cycles unless the data arrives then.
  assign w_timeout = r_mem_rd & ~mem_valid & (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign fetch_err = r_fetch_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt    <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (!r_mem_rd || mem_valid) begin
        r_to_cnt <= '0;
      end else if (!w_timeout) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_inc_pc      <= 1'b0;
      r_load_pc     <= 1'b0;
      r_new_count   <= '0;
      r_halted      <= 1'b0;
      r_settle_cnt  <= '0;
    end else begin
      // PC pulses are single-cycle by default.
      r_inc_pc  <= 1'b0;
      r_load_pc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state    <= S_RD_HI;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= pc_count;
          end
        end
        S_RD_HI: begin
          if (mem_valid) begin
            r_instr[15:8] <= mem_data;
            r_mem_rd      <= 1'b0;
            r_state       <= S_GAP;
          end else if (w_timeout) begin
            r_mem_rd <= 1'b0;
            r_state  <= S_ERR;
          end
        end
        // One idle cycle so the memory sees two distinct requests.
        S_GAP: begin
          r_mem_rd   <= 1'b1;
          r_mem_addr <= w_addr_lo;
          r_state    <= S_RD_LO;
        end
        S_RD_LO: begin
          if (mem_valid) begin
            r_instr[7:0]  <= mem_data;
            r_mem_rd      <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_PRESENT;
          end else if (w_timeout) begin
            r_mem_rd <= 1'b0;
            r_state  <= S_ERR;
          end
        end
        S_PRESENT: begin
          if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_settle_cnt  <= '0;
            if (r_instr[15:12] == HALT_OP) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else if (br_take) begin
              r_load_pc   <= 1'b1;
              r_new_count <= br_target;
              r_state     <= S_SETTLE;
            end else begin
              r_inc_pc <= 1'b1;
              r_state  <= S_SETTLE;
            end
          end
        end
        // First SETTLE cycle carries the pulse; SETTLE_CYC idle cycles follow.
        S_SETTLE: begin
          if (r_settle_cnt == 3'(SETTLE_CYC)) begin
            if (run) begin
              r_state    <= S_RD_HI;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= pc_count;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + 3'd1;
          end
        end
        S_HALT:  r_state <= S_HALT;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign IncPC       = r_inc_pc;
  assign LoadPC      = r_load_pc;
  assign new_count   = r_new_count;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch

module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  pc_count;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_take;
  logic [7:0]  br_target;
  logic        IncPC;
  logic        LoadPC;
  logic [7:0]  new_count;
  logic        halted;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .pc_count    (pc_count),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_take     (br_take),
    .br_target   (br_target),
    .IncPC       (IncPC),
    .LoadPC      (LoadPC),
    .new_count   (new_count),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (mem_rd === 1'b1) break;
      step();
    end
    chk({tag, "_rd"}, {15'd0, mem_rd}, 16'd1);
  endtask

  // Waits for a request, checks its address, answers one cycle later, checks mem_rd drops.
  task automatic serve(input logic [7:0] d, input logic [7:0] exp_addr, input string tag);
    wait_rd(tag);
    chk({tag, "_addr"}, {8'd0, mem_addr}, {8'd0, exp_addr});
    mem_data  = d;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    mem_data  = 8'h00;
    chk({tag, "_drop"}, {15'd0, mem_rd}, 16'd0);
  endtask

  initial begin
    logic any_act;
    int   rd_cycles;

    reset = 1'b0; run = 1'b0; pc_count = 8'h00; mem_data = 8'h00; mem_valid = 1'b0;
    instr_ready = 1'b0; br_take = 1'b0; br_target = 8'h00;
    step(); step();

    // Reset state
    chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_mem_addr", {8'd0, mem_addr}, 16'd0);
    chk("rst_instr", instr, 16'd0);
    chk("rst_instr_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_pulses", {14'd0, IncPC, LoadPC}, 16'd0);
    chk("rst_new_count", {8'd0, new_count}, 16'd0);
    chk("rst_flags", {14'd0, halted, fetch_err}, 16'd0);

    // Basic fetch at 0x00
    reset = 1'b1; run = 1'b1;
    serve(8'h12, 8'h00, "f0_hi");
    serve(8'h34, 8'h01, "f0_lo");
    chk("f0_instr", instr, 16'h1234);
    chk("f0_valid", {15'd0, instr_valid}, 16'd1);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {15'd0, instr_valid}, 16'd1);
      chk("bp_instr", instr, 16'h1234);
      chk("bp_pulses", {14'd0, IncPC, LoadPC}, 16'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("f0_inc", {14'd0, IncPC, LoadPC}, 16'b10);
    chk("f0_valid_clr", {15'd0, instr_valid}, 16'd0);
    pc_count = 8'h02;
    step();
    chk("f0_inc_one", {14'd0, IncPC, LoadPC}, 16'd0);
    step();
    chk("settle_idle", {15'd0, mem_rd}, 16'd0);
    step();
    chk("settle_fetch", {15'd0, mem_rd}, 16'd1);

    // Branch
    serve(8'h20, 8'h02, "f1_hi");
    serve(8'h00, 8'h03, "f1_lo");
    chk("f1_instr", instr, 16'h2000);
    instr_ready = 1'b1; br_take = 1'b1; br_target = 8'h40;
    step();
    instr_ready = 1'b0; br_take = 1'b0;
    chk("br_load", {14'd0, IncPC, LoadPC}, 16'b01);
    chk("br_new_count", {8'd0, new_count}, 16'h0040);
    pc_count = 8'h40;
    step();
    chk("br_load_one", {14'd0, IncPC, LoadPC}, 16'd0);
    serve(8'h11, 8'h40, "f2_hi");
    serve(8'h11, 8'h41, "f2_lo");
    chk("f2_instr", instr, 16'h1111);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("f2_inc", {14'd0, IncPC, LoadPC}, 16'b10);
    pc_count = 8'hFF;

    // Wrap and halt
    serve(8'hF0, 8'hFF, "f3_hi");
    serve(8'h00, 8'h00, "f3_lo");
    chk("f3_instr", instr, 16'hF000);
    instr_ready = 1'b1; br_take = 1'b1; br_target = 8'h55;
    step();
    instr_ready = 1'b0; br_take = 1'b0;
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_pulses", {14'd0, IncPC, LoadPC}, 16'd0);
    any_act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      any_act = any_act | mem_rd | IncPC | LoadPC;
    end
    chk("halt_quiet", {15'd0, any_act}, 16'd0);
    chk("halt_sticky", {15'd0, halted}, 16'd1);
    reset = 1'b0;
    #1;
    chk("halt_reset", {15'd0, halted}, 16'd0);
    step();
    reset = 1'b1;

    // Reset during the low-byte read
    pc_count = 8'h10;
    serve(8'hAB, 8'h10, "f4_hi");
    wait_rd("f4_lo");
    chk("f4_lo_addr", {8'd0, mem_addr}, 16'h0011);
    reset = 1'b0;
    #1;
    chk("mid_rst_rd", {15'd0, mem_rd}, 16'd0);
    chk("mid_rst_addr", {8'd0, mem_addr}, 16'd0);
    chk("mid_rst_instr", instr, 16'd0);
    step();
    reset = 1'b1;

    // Memory never answers
    pc_count = 8'h20;
    wait_rd("to");
    rd_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_rd !== 1'b1) break;
      rd_cycles++;
      step();
    end
`ifdef FETCH_TIMEOUT_EN
    chk("to_cycles", 16'(rd_cycles), 16'd15);
    chk("to_err", {15'd0, fetch_err}, 16'd1);
    chk("to_rd_drop", {15'd0, mem_rd}, 16'd0);
    chk("to_not_halted", {15'd0, halted}, 16'd0);
`else
    chk("to_wait", 16'(rd_cycles), 16'd30);
    chk("to_no_err", {15'd0, fetch_err}, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
